// File: rtl/arm_step_sequencer.sv
// arm_step_sequencer: trapezoidal/triangular step-pulse generator for one arm axis.
// Define ARM_SEQ_RAMP_EN to build the acceleration ramp; otherwise moves run at div_target.
module arm_step_sequencer #(
    parameter int PULSE_CYCLES = 24
) (
    input  logic        clk_12MHz,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        pause,
    input  logic [31:0] steps_in,
    input  logic [31:0] div_target,
    input  logic [31:0] div_start,
    input  logic [15:0] ramp_dec,
    input  logic        limitn,
    input  logic        fault,
    output logic        step_pulse,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic [31:0] steps_remaining
);
    typedef enum logic [1:0] {IDLE, RAMP_UP, CRUISE, RAMP_DOWN} state_t;
    state_t state, state_n;
    logic [31:0] cnt, cnt_n, pcnt, pcnt_n, cur_div, cur_div_n, rem_n;
    logic pulse_n, done_n, bad;
    logic [1:0] err_n;
`ifdef ARM_SEQ_RAMP_EN
    logic [31:0] tgt, tgt_n, dstart, dstart_n, dec, dec_n, rs, rs_n, rs1, dn, c1, up_sat, up;
    logic [32:0] sum;
    assign bad = div_target <= 32'(PULSE_CYCLES) || div_start < div_target;
    // Ramp-up result first; ramp-down is then applied on top of it so a short move peaks early.
    assign dn = cur_div >= dec ? cur_div - dec : '0;
    assign c1 = state == RAMP_UP ? (dn > tgt ? dn : tgt) : cur_div;
    assign rs1 = state == RAMP_UP ? rs + 32'd1 : rs;
    assign sum = {1'b0, c1} + {1'b0, dec};
    assign up_sat = sum[32] ? '1 : sum[31:0];
    assign up = up_sat < dstart ? up_sat : dstart;
`else
    logic unused_ramp;
    assign unused_ramp = ^{div_start, ramp_dec};
    assign bad = div_target <= 32'(PULSE_CYCLES);
`endif
    assign busy = state != IDLE;

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        pcnt_n = pcnt;
        cur_div_n = cur_div;
        rem_n = steps_remaining;
        pulse_n = step_pulse;
        done_n = 1'b0;
        err_n = err;
`ifdef ARM_SEQ_RAMP_EN
        tgt_n = tgt;
        dstart_n = dstart;
        dec_n = dec;
        rs_n = rs;
`endif
        if (busy) begin
            if (abort || fault || !limitn) begin
                state_n = IDLE;
                pulse_n = 1'b0;
                err_n = fault ? 2'd2 : !limitn ? 2'd1 : err;
            end else begin
                if (step_pulse) begin
                    if (pcnt == 32'd1) begin
                        pulse_n = 1'b0;
                        if (steps_remaining == '0) begin
                            state_n = IDLE;
                            done_n = 1'b1;
                        end
                    end else begin
                        pcnt_n = pcnt - 32'd1;
                    end
                end
                if (!pause && steps_remaining != '0) begin
                    if (cnt == 32'd1) begin
                        pulse_n = 1'b1;
                        pcnt_n = 32'(PULSE_CYCLES);
                        rem_n = steps_remaining - 32'd1;
`ifdef ARM_SEQ_RAMP_EN
                        rs_n = rs1;
                        if (state == RAMP_DOWN || rem_n <= rs1) begin
                            state_n = RAMP_DOWN;
                            cur_div_n = up;
                        end else begin
                            cur_div_n = c1;
                            if (state == RAMP_UP && c1 == tgt) state_n = CRUISE;
                        end
`endif
                        cnt_n = cur_div_n;
                    end else begin
                        cnt_n = cnt - 32'd1;
                    end
                end
            end
        end else if (start && !abort && steps_in != '0) begin
            if (bad) begin
                err_n = 2'd3;
            end else begin
                err_n = 2'd0;
                rem_n = steps_in;
`ifdef ARM_SEQ_RAMP_EN
                cur_div_n = div_start;
                tgt_n = div_target;
                dstart_n = div_start;
                dec_n = {16'b0, ramp_dec};
                rs_n = '0;
                state_n = div_start == div_target ? CRUISE : RAMP_UP;
`else
                cur_div_n = div_target;
                state_n = CRUISE;
`endif
                cnt_n = cur_div_n;
            end
        end
    end

    always_ff @(posedge clk_12MHz) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            pcnt <= '0;
            cur_div <= '0;
            steps_remaining <= '0;
            step_pulse <= 1'b0;
            done <= 1'b0;
            err <= 2'd0;
`ifdef ARM_SEQ_RAMP_EN
            tgt <= '0;
            dstart <= '0;
            dec <= '0;
            rs <= '0;
`endif
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            pcnt <= pcnt_n;
            cur_div <= cur_div_n;
            steps_remaining <= rem_n;
            step_pulse <= pulse_n;
            done <= done_n;
            err <= err_n;
`ifdef ARM_SEQ_RAMP_EN
            tgt <= tgt_n;
            dstart <= dstart_n;
            dec <= dec_n;
            rs <= rs_n;
`endif
        end
    end
endmodule
